// File: rtl/uart_pkg.sv
// Shared types for the parametrised UART receiver.
// Parity modes, receiver states and the mid-bit offset helper.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } rx_state_t;

  function automatic int half_of(input int cpb);
    return cpb / 2;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an idle-high asynchronous input.
// Resets to 1 so a line at rest never looks like a start bit.
module uart_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff <= 2'b11;
    else        ff <= {ff[0], d};
  end

  assign q = ff[1];

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with valid/ready output and error flags.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling per bit.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 RX_LINE,
  output logic [DATA_BITS-1:0] DATA,
  output logic                 VALID,
  input  logic                 READY,
  output logic                 BUSY,
  output logic                 FRAME_ERR,
  output logic                 PARITY_ERR,
  output logic                 OVERRUN
);

  localparam int HALF = half_of(CLKS_PER_BIT);
  localparam int CW   = $clog2(CLKS_PER_BIT);
`ifdef UART_RX_MAJORITY_EN
  localparam int START_PT = HALF + 1;
`else
  localparam int START_PT = HALF - 1;
`endif
  localparam logic [CW-1:0] START_END = CW'(START_PT);
  localparam logic [CW-1:0] BIT_END   = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);
  localparam logic USE_PAR = (PARITY != int'(PAR_NONE));
  localparam logic ODD     = (PARITY == int'(PAR_ODD));

  logic                 rx_s;
  logic                 smp;
  rx_state_t            state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [3:0]           idx, idx_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 ferr, ferr_n;
  logic                 perr, perr_n;
  logic                 tick;
  logic                 done;

  uart_sync2 u_sync (
    .clk  (CLK),
    .rst_n(RST_N),
    .d    (RX_LINE),
    .q    (rx_s)
  );

`ifdef UART_RX_MAJORITY_EN
  // Window of three consecutive synchronised samples ending now.
  logic [1:0] hist;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) hist <= 2'b11;
    else        hist <= {hist[0], rx_s};
  end

  assign smp = (hist[1] & hist[0]) |
               (hist[1] & rx_s) |
               (hist[0] & rx_s);
`else
  assign smp = rx_s;
`endif

  always_comb begin
    state_n = state;
    cnt_n   = cnt + CW'(1);
    idx_n   = idx;
    shreg_n = shreg;
    ferr_n  = ferr;
    perr_n  = perr;
    done    = 1'b0;
    tick    = (cnt == BIT_END);
    unique case (state)
      ST_IDLE: begin
        cnt_n  = '0;
        idx_n  = '0;
        ferr_n = 1'b0;
        perr_n = 1'b0;
        if (!rx_s) state_n = ST_START;
      end
      ST_START: begin
        if (cnt == START_END) begin
          cnt_n   = '0;
          state_n = smp ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (tick) begin
          cnt_n   = '0;
          shreg_n = {smp, shreg[DATA_BITS-1:1]};
          idx_n   = idx + 4'd1;
          if (idx == LAST_DATA) begin
            idx_n   = '0;
            state_n = USE_PAR ? ST_PARITY : ST_STOP;
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          cnt_n   = '0;
          perr_n  = ^shreg ^ smp ^ ODD;
          state_n = ST_STOP;
        end
      end
      ST_STOP: begin
        if (tick) begin
          cnt_n  = '0;
          ferr_n = ferr | ~smp;
          idx_n  = idx + 4'd1;
          if (idx == LAST_STOP) begin
            done    = 1'b1;
            state_n = ferr_n ? ST_BREAK : ST_IDLE;
          end
        end
      end
      ST_BREAK: begin
        // Hold off until the line recovers so a stuck-low line
        // cannot retrigger frames.
        cnt_n = '0;
        if (rx_s) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= ST_IDLE;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
      ferr  <= 1'b0;
      perr  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      shreg <= shreg_n;
      ferr  <= ferr_n;
      perr  <= perr_n;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      DATA       <= '0;
      VALID      <= 1'b0;
      FRAME_ERR  <= 1'b0;
      PARITY_ERR <= 1'b0;
      OVERRUN    <= 1'b0;
    end else begin
      OVERRUN <= done & VALID & ~READY;
      if (done) begin
        DATA       <= shreg;
        FRAME_ERR  <= ferr_n;
        PARITY_ERR <= perr;
        VALID      <= 1'b1;
      end else if (VALID && READY) begin
        VALID <= 1'b0;
      end
    end
  end

  assign BUSY = (state != ST_IDLE) && (state != ST_BREAK);

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: an 8N1 and an 8E1 instance driven from
// a frame-level model of delivery time, handshake and busy windows.
module tb_uart_rx_param;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;

  typedef struct {
    int         id;
    int         due;
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } frame_t;

  typedef struct {
    int id;
    int lo;
    int hi;
  } win_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       rx [2];
  logic       rdy [2];
  logic [7:0] d_o [2];
  logic       v_o [2];
  logic       b_o [2];
  logic       fe_o [2];
  logic       pe_o [2];
  logic       ov_o [2];

  frame_t exp_q[$];
  win_t   win_q[$];

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int rdy_mode = 1;

  logic       ev [2];
  logic       ef [2];
  logic       ep [2];
  logic       eo [2];
  logic [7:0] ed [2];

  int         rise_cnt [2];
  int         vh_cnt [2];
  int         ovr_cnt [2];
  int         first_cyc [2];
  int         last_start [2];
  logic [7:0] cap_d [2];
  logic       cap_fe [2];
  logic       cap_pe [2];
  logic       pv [2];

  always #5 clk = ~clk;

  uart_rx_param #(
    .CLKS_PER_BIT(CPB), .DATA_BITS(8),
    .PARITY(0), .STOP_BITS(1)
  ) dut0 (
    .CLK(clk), .RST_N(rst_n), .RX_LINE(rx[0]),
    .DATA(d_o[0]), .VALID(v_o[0]), .READY(rdy[0]),
    .BUSY(b_o[0]), .FRAME_ERR(fe_o[0]),
    .PARITY_ERR(pe_o[0]), .OVERRUN(ov_o[0])
  );

  uart_rx_param #(
    .CLKS_PER_BIT(CPB), .DATA_BITS(8),
    .PARITY(2), .STOP_BITS(1)
  ) dut1 (
    .CLK(clk), .RST_N(rst_n), .RX_LINE(rx[1]),
    .DATA(d_o[1]), .VALID(v_o[1]), .READY(rdy[1]),
    .BUSY(b_o[1]), .FRAME_ERR(fe_o[1]),
    .PARITY_ERR(pe_o[1]), .OVERRUN(ov_o[1])
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s actual=%0h expected=%0h t=%0t",
                 name, act, expv, $time);
    end
  endtask

  function automatic logic exp_busy(input int id);
    logic b;
    b = 1'b0;
    foreach (win_q[k])
      if (win_q[k].id == id && cyc >= win_q[k].lo &&
          cyc < win_q[k].hi) b = 1'b1;
    return b;
  endfunction

  // Model: a frame lands at its due edge; handshake rules apply.
  initial begin
    for (int i = 0; i < 2; i++) begin
      ev[i] = 1'b0; ef[i] = 1'b0; ep[i] = 1'b0;
      eo[i] = 1'b0; ed[i] = 8'h00;
    end
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        for (int i = 0; i < 2; i++) begin
          ev[i] = 1'b0; ef[i] = 1'b0; ep[i] = 1'b0;
          eo[i] = 1'b0; ed[i] = 8'h00;
        end
        exp_q.delete();
        win_q.delete();
      end else begin
        for (int id = 0; id < 2; id++) begin
          int hit;
          hit = -1;
          foreach (exp_q[k])
            if (hit < 0 && exp_q[k].id == id &&
                exp_q[k].due == cyc) hit = k;
          if (hit >= 0) begin
            eo[id] = ev[id] && !rdy[id];
            ev[id] = 1'b1;
            ed[id] = exp_q[hit].d;
            ef[id] = exp_q[hit].fe;
            ep[id] = exp_q[hit].pe;
            exp_q.delete(hit);
          end else begin
            eo[id] = 1'b0;
            if (ev[id] && rdy[id]) ev[id] = 1'b0;
          end
        end
      end
    end
  end

  // Compare every cycle away from the active edge.
  initial begin
    for (int i = 0; i < 2; i++) begin
      rise_cnt[i] = 0; vh_cnt[i] = 0; ovr_cnt[i] = 0;
      first_cyc[i] = 0; pv[i] = 1'b0;
      cap_d[i] = 8'h00; cap_fe[i] = 1'b0; cap_pe[i] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int id = 0; id < 2; id++) begin
        if (!rst_n) begin
          pv[id] = 1'b0;
        end else begin
          chk($sformatf("dut%0d valid", id), 32'(v_o[id]), 32'(ev[id]));
          if (ev[id]) begin
            chk($sformatf("dut%0d data", id), 32'(d_o[id]), 32'(ed[id]));
            chk($sformatf("dut%0d frame_err", id),
                32'(fe_o[id]), 32'(ef[id]));
            chk($sformatf("dut%0d parity_err", id),
                32'(pe_o[id]), 32'(ep[id]));
          end
          chk($sformatf("dut%0d overrun", id), 32'(ov_o[id]), 32'(eo[id]));
          chk($sformatf("dut%0d busy", id),
              32'(b_o[id]), 32'(exp_busy(id)));
          if (v_o[id] && !pv[id]) begin
            rise_cnt[id]++;
            first_cyc[id] = cyc;
            cap_d[id] = d_o[id];
            cap_fe[id] = fe_o[id];
            cap_pe[id] = pe_o[id];
          end
          if (v_o[id]) vh_cnt[id]++;
          if (ov_o[id]) ovr_cnt[id]++;
          pv[id] = v_o[id];
        end
      end
    end
  end

  // READY: 0 forced low, 1 forced high, 2 random per cycle.
  initial begin
    rdy[0] = 1'b1;
    rdy[1] = 1'b1;
    forever begin
      @(negedge clk);
      #1;
      for (int i = 0; i < 2; i++)
        if (rdy_mode == 2) rdy[i] = 1'($urandom_range(0, 1));
        else               rdy[i] = (rdy_mode == 1);
    end
  end

  task automatic send(input int id, input logic [7:0] d,
                      input logic bad_par, input logic bad_stop,
                      input int hold);
    logic   bits[$];
    int     s, n;
    frame_t f;
    win_t   w;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (id == 1) bits.push_back((^d) ^ bad_par);
    bits.push_back(!bad_stop);
    n = (id == 1) ? 10 : 9;
    @(negedge clk);
    s = cyc + 1;
    last_start[id] = s;
    f.id = id;
    f.due = s + 2 + HALF + CPB * n;
    f.d = d;
    f.fe = bad_stop;
    f.pe = (id == 1) && bad_par;
    exp_q.push_back(f);
    w.id = id;
    w.lo = s + 2;
    w.hi = f.due;
    win_q.push_back(w);
    foreach (bits[k]) begin
      rx[id] = bits[k];
      repeat (CPB) @(negedge clk);
    end
    if (bad_stop) repeat (hold) @(negedge clk);
    rx[id] = 1'b1;
  endtask

  task automatic glitch();
    int   s;
    win_t w;
    @(negedge clk);
    s = cyc + 1;
    w.id = 0;
    w.lo = s + 2;
    w.hi = s + 2 + HALF;
    win_q.push_back(w);
    rx[0] = 1'b0;
    repeat (4) @(negedge clk);
    rx[0] = 1'b1;
    repeat (30) @(negedge clk);
  endtask

  task automatic partial_ff();
    int   s;
    win_t w;
    @(negedge clk);
    s = cyc + 1;
    w.id = 0;
    w.lo = s + 2;
    w.hi = s + 100000;
    win_q.push_back(w);
    rx[0] = 1'b0;
    repeat (CPB) @(negedge clk);
    rx[0] = 1'b1;
    repeat (40) @(negedge clk);
  endtask

  task automatic reset_checks();
    for (int id = 0; id < 2; id++) begin
      chk($sformatf("rst%0d data", id), 32'(d_o[id]), 32'h0);
      chk($sformatf("rst%0d valid", id), 32'(v_o[id]), 32'h0);
      chk($sformatf("rst%0d busy", id), 32'(b_o[id]), 32'h0);
      chk($sformatf("rst%0d frame_err", id), 32'(fe_o[id]), 32'h0);
      chk($sformatf("rst%0d parity_err", id), 32'(pe_o[id]), 32'h0);
      chk($sformatf("rst%0d overrun", id), 32'(ov_o[id]), 32'h0);
    end
  endtask

  initial begin
    int r0, h0, o0, id, bs, bp, gap;
    logic [7:0] rd;
    rx[0] = 1'b1;
    rx[1] = 1'b1;
    #1 rst_n = 1'b0;
    #1 reset_checks();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    r0 = rise_cnt[0];
    h0 = vh_cnt[0];
    send(0, 8'hA5, 1'b0, 1'b0, 0);
    repeat (10) @(negedge clk);
    chk("a5 rise", 32'(rise_cnt[0] - r0), 32'd1);
    chk("a5 latency", 32'(first_cyc[0] - last_start[0]), 32'd154);
    chk("a5 data", 32'(cap_d[0]), 32'hA5);
    chk("a5 frame_err", 32'(cap_fe[0]), 32'h0);
    chk("a5 valid cycles", 32'(vh_cnt[0] - h0), 32'd1);

    send(1, 8'h07, 1'b1, 1'b0, 0);
    repeat (10) @(negedge clk);
    chk("par bad data", 32'(cap_d[1]), 32'h07);
    chk("par bad flag", 32'(cap_pe[1]), 32'h1);
    chk("par latency", 32'(first_cyc[1] - last_start[1]), 32'd170);
    send(1, 8'h07, 1'b0, 1'b0, 0);
    repeat (10) @(negedge clk);
    chk("par good flag", 32'(cap_pe[1]), 32'h0);

    r0 = rise_cnt[0];
    glitch();
    chk("glitch no frame", 32'(rise_cnt[0] - r0), 32'd0);
    send(0, 8'h3C, 1'b0, 1'b0, 0);
    repeat (10) @(negedge clk);
    chk("after glitch data", 32'(cap_d[0]), 32'h3C);

    r0 = rise_cnt[0];
    send(0, 8'h5A, 1'b0, 1'b1, 40);
    repeat (60) @(negedge clk);
    chk("break one frame", 32'(rise_cnt[0] - r0), 32'd1);
    chk("break frame_err", 32'(cap_fe[0]), 32'h1);
    chk("break data", 32'(cap_d[0]), 32'h5A);

    rdy_mode = 0;
    repeat (2) @(negedge clk);
    o0 = ovr_cnt[0];
    send(0, 8'h11, 1'b0, 1'b0, 0);
    send(0, 8'h22, 1'b0, 1'b0, 0);
    repeat (10) @(negedge clk);
    chk("ovr pulses", 32'(ovr_cnt[0] - o0), 32'd1);
    chk("ovr valid", 32'(v_o[0]), 32'h1);
    chk("ovr data", 32'(d_o[0]), 32'h22);
    rdy_mode = 1;
    @(negedge clk);
    @(negedge clk);
    chk("ready drop", 32'(v_o[0]), 32'h0);

    partial_ff();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 reset_checks();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    r0 = rise_cnt[0];
    send(0, 8'h81, 1'b0, 1'b0, 0);
    repeat (10) @(negedge clk);
    chk("post reset rise", 32'(rise_cnt[0] - r0), 32'd1);
    chk("post reset data", 32'(cap_d[0]), 32'h81);

    rdy_mode = 2;
    for (int n = 0; n < 24; n++) begin
      id = int'($urandom_range(0, 1));
      rd = 8'($urandom_range(0, 255));
      bs = ($urandom_range(0, 5) == 0) ? 1 : 0;
      bp = ($urandom_range(0, 3) == 0) ? 1 : 0;
      send(id, rd, 1'(bp), 1'(bs),
           bs ? int'($urandom_range(0, 30)) : 0);
      gap = int'($urandom_range(0, 20)) + (bs ? 4 : 0);
      repeat (gap) @(negedge clk);
    end
    rdy_mode = 1;
    repeat (200) @(negedge clk);
    chk("all delivered", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
